// File: rtl/core_axi_wr_bridge.sv
// ----------------------------------------------------------------------------
// core_axi_wr_bridge
//
// Purpose:
//   Turns the StoreUnit's burst-write request/stream interface into a single
//   AXI4 write transaction (AW + W beats + B). Only one burst is in flight at
//   a time. Completion is signalled by a one-cycle wDone pulse. err holds the
//   status of the most recent burst.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   initWrite/writeAddr/       burst request (accepted only while idle)
//   writeLen                   writeLen is the number of beats minus 1
//   wDataValid/wData/mask      core data stream
//   wDataNext                  combinational "beat consumed this cycle"
//   wDone, busy, err           status back to the core
//   aw*, w*, b*                AXI4 write-master channels
//
// Build option:
//   CORE_WR_4K_CHECK_EN - when defined, a burst that would cross a 4 KiB
//   boundary is not issued on AXI. Its beats are drained from the core and
//   discarded, and the burst completes with err = 1.
// ----------------------------------------------------------------------------
module core_axi_wr_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   // core side
   input  logic              initWrite,
   input  logic [ADDR_W-1:0] writeAddr,
   input  logic [7:0]        writeLen,
   input  logic              wDataValid,
   input  logic [DATA_W-1:0] wData,
   input  logic [3:0]        mask,
   output logic              wDataNext,
   output logic              wDone,
   output logic              busy,
   output logic              err,
   // AXI AW channel
   output logic              awvalid,
   input  logic              awready,
   output logic [ADDR_W-1:0] awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   // AXI W channel
   output logic              wvalid,
   input  logic              wready,
   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   output logic              wlast,
   // AXI B channel
   input  logic              bvalid,
   output logic              bready,
   input  logic [1:0]        bresp
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t            state_q,      state_d;
   logic              awvalid_q,    awvalid_d;
   logic              aw_done_q,    aw_done_d;
   logic              w_done_q,     w_done_d;
   logic [ADDR_W-1:0] awaddr_q,     awaddr_d;
   logic [7:0]        awlen_q,      awlen_d;
   logic [7:0]        cnt_q,        cnt_d;
   logic              beats_left_q, beats_left_d;
   logic              wvalid_q,     wvalid_d;
   logic [DATA_W-1:0] wdata_q,      wdata_d;
   logic [3:0]        wstrb_q,      wstrb_d;
   logic              wlast_q,      wlast_d;
   logic              wdone_q,      wdone_d;
   logic              busy_q,       busy_d;
   logic              err_q,        err_d;
   logic              drain_q,      drain_d;

   logic w_next;
   logic aw_hs;
   logic w_hs;
   logic wlast_hs;
   logic reject;

   // A request is rejected when its last byte would land past the 4 KiB page
   // that holds its first byte. 14 bits hold the worst case 4095 + 256*4.
`ifdef CORE_WR_4K_CHECK_EN
   logic [13:0] span_end;
   assign span_end = {2'b00, writeAddr[11:0]} + {4'b0000, writeLen, 2'b00} + 14'd4;
   assign reject   = (span_end > 14'd4096);
`else
   assign reject = 1'b0;
`endif

   // A beat is taken from the core only when the holding register is free,
   // or will be freed by a W handshake in this same cycle.
   assign w_next   = wDataValid && (state_q == S_BURST) && beats_left_q
                     && (!wvalid_q || wready);
   assign aw_hs    = awvalid_q && awready;
   assign w_hs     = wvalid_q && wready;
   assign wlast_hs = w_hs && wlast_q;

   // --------------------------------------------------------------------------
   // Next-state and datapath logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d gets a default before the case so no path can leave a
      // variable unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      awvalid_d    = awvalid_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      awaddr_d     = awaddr_q;
      awlen_d      = awlen_q;
      cnt_d        = cnt_q;
      beats_left_d = beats_left_q;
      wvalid_d     = wvalid_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      wlast_d      = wlast_q;
      wdone_d      = 1'b0;
      busy_d       = busy_q;
      err_d        = err_q;
      drain_d      = drain_q;

      unique case (state_q)
         S_IDLE: begin
            if (initWrite) begin
               awaddr_d     = writeAddr;
               awlen_d      = writeLen;
               cnt_d        = writeLen;
               beats_left_d = 1'b1;
               aw_done_d    = 1'b0;
               w_done_d     = 1'b0;
               err_d        = 1'b0;
               busy_d       = 1'b1;
               drain_d      = reject;
               awvalid_d    = !reject;
               state_d      = S_BURST;
            end
         end

         S_BURST: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end

            if (w_next) begin
               // The final beat stops further consumption rather than
               // decrementing, so the counter can never wrap.
               if (cnt_q == 8'd0) beats_left_d = 1'b0;
               else               cnt_d        = cnt_q - 8'd1;
               if (!drain_q) begin
                  wvalid_d = 1'b1;
                  wdata_d  = wData;
                  wstrb_d  = mask;
                  wlast_d  = (cnt_q == 8'd0);
               end
            end else if (w_hs) begin
               wvalid_d = 1'b0;
               wlast_d  = 1'b0;
            end

            if (wlast_hs) w_done_d = 1'b1;

            if (drain_q) begin
               // Rejected burst: once the last beat is swallowed, finish
               // without touching the B channel.
               if (w_next && (cnt_q == 8'd0)) begin
                  drain_d = 1'b0;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
                  wdone_d = 1'b1;
                  state_d = S_IDLE;
               end
            end else if ((aw_done_q || aw_hs) && (w_done_q || wlast_hs)) begin
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            if (bvalid) begin
               err_d   = (bresp != 2'b00);
               busy_d  = 1'b0;
               wdone_d = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   // NOTE: the address/data registers are reset along with the control flags
   // so every output reads 0 immediately after reset, not stale burst data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         awvalid_q    <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         awaddr_q     <= '0;
         awlen_q      <= '0;
         cnt_q        <= '0;
         beats_left_q <= 1'b0;
         wvalid_q     <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         wlast_q      <= 1'b0;
         wdone_q      <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         drain_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so all registers update from
         // the same pre-edge values, independent of statement order.
         state_q      <= state_d;
         awvalid_q    <= awvalid_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         awaddr_q     <= awaddr_d;
         awlen_q      <= awlen_d;
         cnt_q        <= cnt_d;
         beats_left_q <= beats_left_d;
         wvalid_q     <= wvalid_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         wlast_q      <= wlast_d;
         wdone_q      <= wdone_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         drain_q      <= drain_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign wDataNext = w_next;
   assign wDone     = wdone_q;
   assign busy      = busy_q;
   assign err       = err_q;

   assign awvalid   = awvalid_q;
   assign awaddr    = awaddr_q;
   assign awlen     = awlen_q;
   assign awsize    = 3'b010;   // 4-byte beats
   assign awburst   = 2'b01;    // INCR

   assign wvalid    = wvalid_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign wlast     = wlast_q;

   assign bready    = (state_q == S_RESP);

endmodule
